// File: rtl/tlp_cpl_pkg.sv
// Shared types, TLP constants and header-packing helpers for the completion transmitter.
// Contents:
//   FMT_TYPE_* / CPL_STATUS_* - completion header field codes
//   req_t                     - queued read request {tag, rid, addr}, 56 bits
//   cpl_state_e               - transmitter FSM states
//   pack_dw0/1/2, pack_hdr01  - completion header DW builders
package tlp_cpl_pkg;

  localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;
  localparam logic [7:0] FMT_TYPE_CPL  = 8'h0A;
  localparam logic [2:0] CPL_STATUS_SC = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR = 3'b001;

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [31:0] addr;
  } req_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitData,
    StSend
  } cpl_state_e;

  function automatic logic [31:0] pack_dw0(input logic [7:0] fmt_type, input logic [9:0] len);
    return {fmt_type, 14'b0, len};
  endfunction

  function automatic logic [31:0] pack_dw1(input logic [15:0] cpl_id, input logic [2:0] status,
                                           input logic [11:0] byte_cnt);
    return {cpl_id, status, 1'b0, byte_cnt};
  endfunction

  function automatic logic [31:0] pack_dw2(input logic [15:0] rid, input logic [7:0] tag,
                                           input logic [6:0] lo_addr);
    return {rid, tag, 1'b0, lo_addr};
  endfunction

  // DW0/DW1 pair: successful CplD carrying one DW, or a data-less UR Cpl.
  function automatic logic [63:0] pack_hdr01(input logic ur, input logic [15:0] cpl_id);
    logic [63:0] hdr;
    if (ur) begin
      hdr = {pack_dw0(FMT_TYPE_CPL, 10'd0), pack_dw1(cpl_id, CPL_STATUS_UR, 12'd4)};
    end else begin
      hdr = {pack_dw0(FMT_TYPE_CPLD, 10'd1), pack_dw1(cpl_id, CPL_STATUS_SC, 12'd4)};
    end
    return hdr;
  endfunction

endpackage

// File: rtl/tlp_req_fifo.sv
// Synchronous FIFO holding pending read requests (req_t, 56 bits wide).
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i, wdata_i    - write strobe and request (ignored when full)
//   pop_i              - remove head entry (ignored when empty)
//   rdata_o            - head entry (meaningful only when !empty_o)
//   full_o, empty_o    - occupancy flags
module tlp_req_fifo
  import tlp_cpl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  req_t wdata_i,
  input  logic pop_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  req_t          mem_q [Depth];
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tlp_cpl_tx.sv
// Completion transmitter: queues read requests, issues one read at a time to the
// register/VRAM side and emits each result as a single-beat 256-bit CplD TLP,
// honouring tl_tx_wait backpressure. Completions leave in request order.
// Optional build macro CPL_TIMEOUT_EN: a read that sees no data for TIMEOUT_CYCLES
// cycles is answered with an Unsupported Request Cpl (no data).
// Ports:
//   tlp_clk, rst_n                         - clock, asynchronous active-low reset
//   req_valid/req_ready, req_tag/rid/addr  - request push interface
//   rd_en, rd_addr                         - one-cycle read strobe and address
//   rd_data_valid, rd_data                 - read return
//   tl_tx_wait, tl_tx_valid/sop/eop/data   - TLP transmit beat
//   busy                                   - work pending or in flight
//   err_unexp_rdata                        - sticky: read data arrived unrequested
module tlp_cpl_tx
  import tlp_cpl_pkg::*;
#(
  parameter int unsigned REQ_DEPTH      = 4,
  parameter logic [15:0] COMPLETER_ID   = 16'h0100,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         tlp_clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [7:0]   req_tag,
  input  logic [15:0]  req_rid,
  input  logic [31:0]  req_addr,
  output logic         rd_en,
  output logic [31:0]  rd_addr,
  input  logic         rd_data_valid,
  input  logic [31:0]  rd_data,
  input  logic         tl_tx_wait,
  output logic         tl_tx_valid,
  output logic         tl_tx_sop,
  output logic         tl_tx_eop,
  output logic [255:0] tl_tx_data,
  output logic         busy,
  output logic         err_unexp_rdata
);

  if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("REQ_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  req_t fifo_wdata, fifo_head;
  logic fifo_full, fifo_empty, fifo_push;

  cpl_state_e     state_q, state_d;
  logic [31:0]    dw2_q, dw2_d;
  logic           tx_valid_q, tx_valid_d;
  logic [255:0]   tx_data_q, tx_data_d;
  logic           err_q, err_d;

`ifdef CPL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign fifo_wdata = '{tag: req_tag, rid: req_rid, addr: req_addr};
  assign req_ready  = !fifo_full;
  // Gated by full only, so a push is refused even when a pop happens the same cycle.
  assign fifo_push  = req_valid && !fifo_full;

  tlp_req_fifo #(
    .Depth (REQ_DEPTH)
  ) u_req_fifo (
    .clk_i   (tlp_clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (rd_en),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rd_en   = (state_q == StIdle) && !fifo_empty;
  assign rd_addr = rd_en ? fifo_head.addr : '0;
  assign busy    = (state_q != StIdle) || !fifo_empty;

  assign tl_tx_valid     = tx_valid_q;
  assign tl_tx_sop       = tx_valid_q;
  assign tl_tx_eop       = tx_valid_q;
  assign tl_tx_data      = tx_data_q;
  assign err_unexp_rdata = err_q;

  always_comb begin
    state_d    = state_q;
    dw2_d      = dw2_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
`ifdef CPL_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          // Head is popped this edge; keep only what the completion header needs.
          dw2_d   = pack_dw2(fifo_head.rid, fifo_head.tag, fifo_head.addr[6:0]);
          state_d = StWaitData;
`ifdef CPL_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      StWaitData: begin
        if (rd_data_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {pack_hdr01(1'b0, COMPLETER_ID), dw2_q, rd_data, 128'b0};
          state_d    = StSend;
`ifdef CPL_TIMEOUT_EN
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {pack_hdr01(1'b1, COMPLETER_ID), dw2_q, 32'b0, 128'b0};
          state_d    = StSend;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
`endif
        end
      end
      StSend: begin
        if (!tl_tx_wait) begin
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
          state_d    = StIdle;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
        state_d    = StIdle;
      end
    endcase

    if (rd_data_valid && (state_q != StWaitData)) err_d = 1'b1;
  end

  always_ff @(posedge tlp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dw2_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef CPL_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dw2_q      <= dw2_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
`ifdef CPL_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tlp_cpl_tx.sv
// Self-checking bench for tlp_cpl_tx: table-driven single reads plus hand-written
// backpressure, queue-full, unexpected-data, reset and timeout sequences.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_tlp_cpl_tx;

  localparam logic [31:0] CplDDw0 = 32'h4A000001;
  localparam logic [31:0] CplDDw1 = 32'h01000004;

  logic         tlp_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_tag = '0;
  logic [15:0]  req_rid = '0;
  logic [31:0]  req_addr = '0;
  logic         rd_en;
  logic [31:0]  rd_addr;
  logic         rd_data_valid = 1'b0;
  logic [31:0]  rd_data = '0;
  logic         tl_tx_wait = 1'b0;
  logic         tl_tx_valid, tl_tx_sop, tl_tx_eop;
  logic [255:0] tl_tx_data;
  logic         busy;
  logic         err_unexp_rdata;

  tlp_cpl_tx #(
    .REQ_DEPTH      (4),
    .COMPLETER_ID   (16'h0100),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .tlp_clk         (tlp_clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_tag         (req_tag),
    .req_rid         (req_rid),
    .req_addr        (req_addr),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data_valid   (rd_data_valid),
    .rd_data         (rd_data),
    .tl_tx_wait      (tl_tx_wait),
    .tl_tx_valid     (tl_tx_valid),
    .tl_tx_sop       (tl_tx_sop),
    .tl_tx_eop       (tl_tx_eop),
    .tl_tx_data      (tl_tx_data),
    .busy            (busy),
    .err_unexp_rdata (err_unexp_rdata)
  );

  always #5 tlp_clk = ~tlp_clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [255:0] beat_q[$];

  // Accepted beats: sampled after the falling-edge drivers, i.e. exactly what the
  // next rising edge will see.
  always @(negedge tlp_clk) begin
    #2;
    if (rst_n && tl_tx_valid && !tl_tx_wait) begin
      beats++;
      beat_q.push_back(tl_tx_data);
    end
  end

  task automatic nx();
    @(negedge tlp_clk);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [31:0] data;
    int          lat;
    logic [31:0] exp_dw2;
  } vec_t;

  vec_t vecs[4];

  // One request -> read -> beat, with data returned lat cycles after rd_en.
  task automatic run_read(input vec_t v);
    int b0;
    b0 = beats;
    chk({v.name, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_tag   = v.tag;
    req_rid   = v.rid;
    req_addr  = v.addr;
    nx();
    req_valid = 1'b0;
    chk({v.name, "_rd_en"}, rd_en, 1'b1);
    chk({v.name, "_rd_addr"}, rd_addr, v.addr);
    for (int i = 0; i < v.lat; i++) nx();
    chk({v.name, "_no_beat_yet"}, tl_tx_valid, 1'b0);
    rd_data_valid = 1'b1;
    rd_data       = v.data;
    nx();
    rd_data_valid = 1'b0;
    chk({v.name, "_strobes"}, {tl_tx_valid, tl_tx_sop, tl_tx_eop}, 3'b111);
    chk({v.name, "_beat"}, tl_tx_data, {CplDDw0, CplDDw1, v.exp_dw2, v.data, 128'h0});
    nx();
    chk({v.name, "_idle_valid"}, tl_tx_valid, 1'b0);
    chk({v.name, "_idle_data"}, tl_tx_data, 256'h0);
    chk({v.name, "_one_beat"}, beats, b0 + 1);
  endtask

  int           b0, hold_cnt, n;
  logic         stable;
  logic [255:0] first;

  initial begin
    vecs[0] = '{"rd_f800", 32'h0000F800, 8'h04, 16'h0000, 32'h00000102, 2, 32'h00000400};
    vecs[1] = '{"rd_1234", 32'h00001234, 8'hA5, 16'hBEEF, 32'hDEADBEEF, 1, 32'hBEEFA534};
    vecs[2] = '{"rd_ones", 32'hFFFFFFFF, 8'hFF, 16'hFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFF7F};
    vecs[3] = '{"rd_00c0", 32'h000000C0, 8'h01, 16'h0102, 32'h12345678, 5, 32'h01020140};

    // Reset state
    nx();
    chk("rst_valid", {tl_tx_valid, tl_tx_sop, tl_tx_eop}, 3'b000);
    chk("rst_data", tl_tx_data, 256'h0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_unexp_rdata, 1'b0);
    nx();
    nx();
    rst_n = 1'b1;
    nx();
    chk("rst_ready", req_ready, 1'b1);

    for (int i = 0; i < 4; i++) run_read(vecs[i]);

    // Backpressure: wait held for five SEND cycles.
    tl_tx_wait = 1'b1;
    req_valid  = 1'b1;
    req_tag    = 8'h22;
    req_rid    = 16'h1234;
    req_addr   = 32'h00002008;
    nx();
    req_valid     = 1'b0;
    nx();
    rd_data_valid = 1'b1;
    rd_data       = 32'hA5A55A5A;
    nx();
    rd_data_valid = 1'b0;
    b0       = beats;
    first    = tl_tx_data;
    hold_cnt = 0;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tl_tx_valid) begin
        hold_cnt++;
        if (tl_tx_data !== first) stable = 1'b0;
      end
      if (i == 5) tl_tx_wait = 1'b0;
      nx();
    end
    chk("bp_beat", first, {CplDDw0, CplDDw1, 32'h12342208, 32'hA5A55A5A, 128'h0});
    chk("bp_hold_cycles", hold_cnt, 6);
    chk("bp_stable", stable, 1'b1);
    chk("bp_one_beat", beats, b0 + 1);

    // Queue full: six back-to-back requests while the first read is stalled.
    beat_q.delete();
    fork
      begin : producer
        for (int t = 0; t < 6; t++) begin
          req_valid = 1'b1;
          req_tag   = 8'(t);
          req_rid   = 16'h0055;
          req_addr  = 32'h00001000 + 32'(t * 4);
          if (t == 5) chk("q_full_ready", req_ready, 1'b0);
          if (t == 5) chk("q_full_busy", busy, 1'b1);
          n = 0;
          while (!req_ready && n < 100) begin
            nx();
            n++;
          end
          if (!req_ready) bound_fail("q_push_wait");
          nx();
        end
        req_valid = 1'b0;
      end
      begin : server
        for (int t = 0; t < 6; t++) begin
          int k;
          k = 0;
          while (!rd_en && k < 100) begin
            nx();
            k++;
          end
          if (!rd_en) begin
            bound_fail("q_rd_en_wait");
            break;
          end
          chk($sformatf("q_rd_addr%0d", t), rd_addr, 32'h00001000 + 32'(t * 4));
          for (int d = 0; d < ((t == 0) ? 12 : 2); d++) nx();
          rd_data_valid = 1'b1;
          rd_data       = 32'hC0DE0000 + 32'(t);
          nx();
          rd_data_valid = 1'b0;
        end
      end
    join
    for (int i = 0; i < 4; i++) nx();
    chk("q_beat_count", beat_q.size(), 6);
    for (int t = 0; t < 6 && t < beat_q.size(); t++) begin
      logic [6:0] lo;
      lo = 7'(t * 4);
      chk($sformatf("q_beat%0d", t), beat_q[t],
          {CplDDw0, CplDDw1, 16'h0055, 8'(t), 1'b0, lo, 32'hC0DE0000 + 32'(t), 128'h0});
    end

    // Unexpected read data while idle.
    chk("ux_err_before", err_unexp_rdata, 1'b0);
    b0 = beats;
    rd_data_valid = 1'b1;
    rd_data       = 32'h0BADF00D;
    nx();
    rd_data_valid = 1'b0;
    nx();
    chk("ux_err_set", err_unexp_rdata, 1'b1);
    chk("ux_no_valid", tl_tx_valid, 1'b0);
    chk("ux_not_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++) nx();
    chk("ux_err_sticky", err_unexp_rdata, 1'b1);
    chk("ux_no_beat", beats, b0);

    // Reset while a beat is stalled in SEND.
    tl_tx_wait = 1'b1;
    req_valid  = 1'b1;
    req_tag    = 8'h77;
    req_rid    = 16'h0001;
    req_addr   = 32'h00000010;
    nx();
    req_valid     = 1'b0;
    nx();
    rd_data_valid = 1'b1;
    rd_data       = 32'h11112222;
    nx();
    rd_data_valid = 1'b0;
    chk("rs_pre_valid", tl_tx_valid, 1'b1);
    b0    = beats;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", {tl_tx_valid, tl_tx_sop, tl_tx_eop}, 3'b000);
    chk("rs_data", tl_tx_data, 256'h0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_err_clr", err_unexp_rdata, 1'b0);
    nx();
    nx();
    rst_n      = 1'b1;
    tl_tx_wait = 1'b0;
    for (int i = 0; i < 6; i++) nx();
    chk("rs_no_beat", beats, b0);
    chk("rs_rd_en", rd_en, 1'b0);
    chk("rs_ready", req_ready, 1'b1);

`ifdef CPL_TIMEOUT_EN
    // No data: UR completion after 16 cycles, late data flagged.
    req_valid = 1'b1;
    req_tag   = 8'h09;
    req_rid   = 16'h4321;
    req_addr  = 32'h00000085;
    nx();
    req_valid = 1'b0;
    chk("to_rd_en", rd_en, 1'b1);
    for (int i = 0; i < 16; i++) nx();
    chk("to_not_yet", tl_tx_valid, 1'b0);
    nx();
    chk("to_valid", tl_tx_valid, 1'b1);
    chk("to_beat", tl_tx_data, {32'h0A000000, 32'h01002004, 32'h43210905, 32'h0, 128'h0});
    rd_data_valid = 1'b1;
    rd_data       = 32'hFEEDFACE;
    nx();
    rd_data_valid = 1'b0;
    nx();
    chk("to_late_err", err_unexp_rdata, 1'b1);
    chk("to_done", tl_tx_valid, 1'b0);
`else
    // No data: the read must wait indefinitely.
    b0        = beats;
    req_valid = 1'b1;
    req_tag   = 8'h09;
    req_rid   = 16'h4321;
    req_addr  = 32'h00000085;
    nx();
    req_valid = 1'b0;
    chk("nt_rd_en", rd_en, 1'b1);
    for (int i = 0; i < 40; i++) nx();
    chk("nt_no_beat", tl_tx_valid, 1'b0);
    chk("nt_busy", busy, 1'b1);
    rd_data_valid = 1'b1;
    rd_data       = 32'h0000ABCD;
    nx();
    rd_data_valid = 1'b0;
    chk("nt_beat", tl_tx_data, {CplDDw0, CplDDw1, 32'h43210905, 32'h0000ABCD, 128'h0});
    nx();
    chk("nt_one_beat", beats, b0 + 1);
    chk("nt_err", err_unexp_rdata, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
